// File: rtl/adxl_spi_master.sv
// ADXL345 register-access SPI master: one 16-bit mode-3 frame per accepted request,
// with a guaranteed CS-high gap between frames.
module adxl_spi_master #(
    parameter int CLK_DIV = 25,
    parameter int CS_IDLE = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_i,
    input  logic       rw_ni,
    input  logic [5:0] addr_i,
    input  logic [7:0] wr_data_i,
    output logic       ack_o,
    output logic [7:0] rd_data_o,
    output logic       busy_o,
    output logic       spi_sclk_o,
    output logic       spi_cs_no,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i
);

    localparam int CMAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [3:0]      bit_idx;
    logic [15:0]     tx;
    logic [7:0]      rx;
    logic            rw_q;
    logic [15:0]     frame;
    logic            div_wrap;

    // MB bit is always 0: the sequencer only does single-byte accesses.
    assign frame    = {rw_ni, 1'b0, addr_i, rw_ni ? 8'h00 : wr_data_i};
    assign div_wrap = (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            tx         <= '0;
            rx         <= '0;
            rw_q       <= 1'b0;
            ack_o      <= 1'b0;
            rd_data_o  <= 8'h00;
            busy_o     <= 1'b0;
            spi_sclk_o <= 1'b1;
            spi_cs_no  <= 1'b1;
            spi_mosi_o <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            if (state == SETUP || state == SHIFT || state == HOLD)
                cnt <= div_wrap ? '0 : cnt + CW'(1);
            case (state)
                IDLE: if (req_i) begin
                    state      <= SETUP;
                    cnt        <= '0;
                    bit_idx    <= '0;
                    tx         <= frame;
                    rw_q       <= rw_ni;
                    spi_cs_no  <= 1'b0;
                    spi_mosi_o <= frame[15];
                    busy_o     <= 1'b1;
                end
                SETUP: if (div_wrap) begin
                    state      <= SHIFT;
                    spi_sclk_o <= 1'b0;
                    spi_mosi_o <= tx[15];
                    tx         <= {tx[14:0], 1'b0};
                end
                SHIFT: if (div_wrap) begin
                    if (spi_sclk_o) begin
                        spi_sclk_o <= 1'b0;
                        spi_mosi_o <= tx[15];
                        tx         <= {tx[14:0], 1'b0};
                        bit_idx    <= bit_idx + 4'd1;
                    end else begin
                        spi_sclk_o <= 1'b1;
                        rx         <= {rx[6:0], spi_miso_i};
                        if (bit_idx == 4'd15) state <= HOLD;
                    end
                end
                HOLD: if (div_wrap) begin
                    state      <= GAP;
                    cnt        <= '0;
                    spi_cs_no  <= 1'b1;
                    spi_mosi_o <= 1'b0;
                    ack_o      <= 1'b1;
                    if (rw_q) rd_data_o <= rx;
                end
                GAP: begin
                    // Return one cycle early so the next accept lands exactly CS_IDLE after frame end.
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(CS_IDLE - 2)) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adxl_spi_master.sv
// Directed bench for adxl_spi_master: default divider instance plus a CLK_DIV=2 instance,
// each with a mode-3 sensor model that records MOSI and serves a read byte.
module tb_adxl_spi_master;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_n;
    logic       req, rw_n, ack, busy, sclk, cs_n, mosi;
    logic       miso = 1'b0;
    logic [5:0] addr;
    logic [7:0] wd, rd;
    logic       req2, rw2, ack2, busy2, sclk2, cs2, mosi2;
    logic       miso2 = 1'b0;
    logic [5:0] addr2;
    logic [7:0] wd2, rd2;

    adxl_spi_master dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .rw_ni(rw_n), .addr_i(addr),
        .wr_data_i(wd), .ack_o(ack), .rd_data_o(rd), .busy_o(busy),
        .spi_sclk_o(sclk), .spi_cs_no(cs_n), .spi_mosi_o(mosi), .spi_miso_i(miso)
    );

    adxl_spi_master #(.CLK_DIV(2), .CS_IDLE(4)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .rw_ni(rw2), .addr_i(addr2),
        .wr_data_i(wd2), .ack_o(ack2), .rd_data_o(rd2), .busy_o(busy2),
        .spi_sclk_o(sclk2), .spi_cs_no(cs2), .spi_mosi_o(mosi2), .spi_miso_i(miso2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Sensor models: reset on CS fall, capture MOSI on rising SCLK, drive data byte on falling SCLK.
    logic [15:0] cap = '0, cap2 = '0;
    int          rise = 0, fall = 0, rise2 = 0, fall2 = 0;
    logic [7:0]  sbyte = '0, sbyte2 = '0;
    logic        cs_q = 1'b1, sclk_q = 1'b1, cs2_q = 1'b1, sclk2_q = 1'b1;

    always @(cs_n or sclk) begin
        if (cs_q && !cs_n) begin
            rise = 0; fall = 0; cap = '0;
        end else if (!cs_n && !sclk_q && sclk) begin
            cap = {cap[14:0], mosi}; rise++;
        end else if (!cs_n && sclk_q && !sclk) begin
            miso = (fall >= 8) ? sbyte[3'(15 - fall)] : 1'b0; fall++;
        end
        cs_q = cs_n; sclk_q = sclk;
    end

    always @(cs2 or sclk2) begin
        if (cs2_q && !cs2) begin
            rise2 = 0; fall2 = 0; cap2 = '0;
        end else if (!cs2 && !sclk2_q && sclk2) begin
            cap2 = {cap2[14:0], mosi2}; rise2++;
        end else if (!cs2 && sclk2_q && !sclk2) begin
            miso2 = (fall2 >= 8) ? sbyte2[3'(15 - fall2)] : 1'b0; fall2++;
        end
        cs2_q = cs2; sclk2_q = sclk2;
    end

    int ncmp = 0, nfail = 0, t0 = 0, lat, cs_hi, busy_lo, n_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input bit sel, input bit r, input logic [5:0] a, input logic [7:0] d,
                         input bit hold);
        @(negedge clk);
        if (sel) begin req2 = 1'b1; rw2 = r; addr2 = a; wd2 = d; end
        else     begin req = 1'b1;  rw_n = r; addr = a; wd = d; end
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        if (!hold) begin req = 1'b0; req2 = 1'b0; end
    endtask

    // Returns at the negedge where ack is seen; lat = -1 on timeout.
    task automatic wait_ack(input bit sel, input bit scr, output int l);
        l = -1;
        for (int i = 0; i < 2000; i++) begin
            if (scr) begin addr = 6'($urandom); wd = 8'($urandom); end
            if (sel ? ack2 : ack) begin l = cyc - t0; break; end
            @(negedge clk);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = 1'b0; rw_n = 1'b1; addr = '0; wd = '0;
        req2 = 1'b0; rw2 = 1'b1; addr2 = '0; wd2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd1);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd", 32'(rd), 32'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_cs", 32'(cs_n), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        // Write 0x08 to 0x31
        start(0, 1'b0, 6'h31, 8'h08, 1'b0);
        chk("wr_acc_busy", 32'(busy), 32'd1);
        chk("wr_acc_cs", 32'(cs_n), 32'd0);
        chk("wr_acc_mosi", 32'(mosi), 32'd0);
        wait_ack(0, 1'b0, lat);
        chk("wr_lat", 32'(lat), 32'd825);
        chk("wr_mosi", 32'(cap), 32'h3108);
        chk("wr_rises", 32'(rise), 32'd16);
        chk("wr_rd", 32'(rd), 32'h00);
        chk("wr_end_cs", 32'(cs_n), 32'd1);
        chk("wr_gap_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("wr_ack_pulse", 32'(ack), 32'd0);
        repeat (5) @(negedge clk);
        chk("wr_idle_busy", 32'(busy), 32'd0);

        // Read 0x32, sensor returns 0xA5
        sbyte = 8'hA5;
        start(0, 1'b1, 6'h32, 8'h77, 1'b0);
        chk("rd_acc_mosi", 32'(mosi), 32'd1);
        wait_ack(0, 1'b0, lat);
        chk("rd_lat", 32'(lat), 32'd825);
        chk("rd_mosi", 32'(cap), 32'hB200);
        chk("rd_data", 32'(rd), 32'hA5);
        repeat (8) @(negedge clk);

        // Write with inputs scrambled after accept; rd_data must hold 0xA5
        start(0, 1'b0, 6'h15, 8'hC3, 1'b0);
        wait_ack(0, 1'b1, lat);
        addr = '0; wd = '0;
        chk("iso_lat", 32'(lat), 32'd825);
        chk("iso_mosi", 32'(cap), 32'h15C3);
        chk("iso_rd_hold", 32'(rd), 32'hA5);
        repeat (8) @(negedge clk);

        // Back-to-back reads with req held; address updated 2 cycles after ack
        sbyte = 8'h5A;
        start(0, 1'b1, 6'h0F, 8'h00, 1'b1);
        wait_ack(0, 1'b0, lat);
        chk("b2b_lat1", 32'(lat), 32'd825);
        chk("b2b_mosi1", 32'(cap), 32'h8F00);
        chk("b2b_rd1", 32'(rd), 32'h5A);
        sbyte = 8'hE5;
        cs_hi = 0; busy_lo = 0;
        for (int k = 0; k < 10; k++) begin
            if (cs_n) cs_hi++;
            if (!busy) busy_lo++;
            @(negedge clk);
            if (k == 1) addr = 6'h2D;
        end
        chk("b2b_cs_gap", 32'(cs_hi), 32'd4);
        chk("b2b_busy_low", 32'(busy_lo), 32'd1);
        wait_ack(0, 1'b0, lat);
        req = 1'b0;
        chk("b2b_lat2", 32'(lat), 32'd1654);
        chk("b2b_mosi2", 32'(cap), 32'hAD00);
        chk("b2b_rd2", 32'(rd), 32'hE5);
        repeat (8) @(negedge clk);

        // Reset in the middle of a frame
        start(0, 1'b0, 6'h2C, 8'h0A, 1'b0);
        for (int k = 0; k < 2000 && rise < 7; k++) @(negedge clk);
        chk("mid_bit7", 32'(rise), 32'd7);
        rst_n = 1'b0;
        #1;
        chk("mid_cs", 32'(cs_n), 32'd1);
        chk("mid_sclk", 32'(sclk), 32'd1);
        chk("mid_mosi", 32'(mosi), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_rd", 32'(rd), 32'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n_ack = 0;
        repeat (900) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
        chk("mid_no_ack", 32'(n_ack), 32'd0);

        // Clean frame after reset: full SETUP before first falling SCLK
        sbyte = 8'h81;
        start(0, 1'b1, 6'h00, 8'h00, 1'b0);
        repeat (24) @(negedge clk);
        chk("post_setup_hi", 32'(sclk), 32'd1);
        @(negedge clk);
        chk("post_first_fall", 32'(sclk), 32'd0);
        wait_ack(0, 1'b0, lat);
        chk("post_lat", 32'(lat), 32'd825);
        chk("post_mosi", 32'(cap), 32'h8000);
        chk("post_rd", 32'(rd), 32'h81);

        // CLK_DIV=2 instance: SCLK period 4 clocks, ack at accept+66
        sbyte2 = 8'h3C;
        start(1, 1'b1, 6'h11, 8'h00, 1'b0);
        @(negedge clk);
        chk("d2_setup_hi", 32'(sclk2), 32'd1);
        @(negedge clk);
        chk("d2_fall0", 32'(sclk2), 32'd0);
        repeat (2) @(negedge clk);
        chk("d2_rise0", 32'(sclk2), 32'd1);
        wait_ack(1, 1'b0, lat);
        chk("d2_lat", 32'(lat), 32'd66);
        chk("d2_mosi", 32'(cap2), 32'h9100);
        chk("d2_rises", 32'(rise2), 32'd16);
        chk("d2_rd", 32'(rd2), 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
